nios2_cpu_ocimem_arbiter: RTL and testbench

Sequences and shares the debug on-chip-instrumentation (OCI) RAM between two requesters. One requester is the JTAG debug path, which is driven by the sysclk-domain `take_action_ocimem_*` strobes and the `jdo` shift data. The other is the CPU's Avalon debug-memory slave. The block sits beside the debug slave wrapper in the CPU clock domain, owns the single RAM port, and returns JTAG read data as `MonDReg` with the `monitor_ready` handshake.

---
 rtl/nios2_cpu_ocimem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_nios2_cpu_ocimem_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_cpu_ocimem_arbiter.sv
// OCI RAM arbiter: shares one RAM port between the JTAG debug path and the
// CPU Avalon debug slave (round-robin), and returns JTAG reads via MonDReg.
// Ports: clk/reset_n; jdo + take_*_ocimem_* strobes (JTAG side);
//   av_* (CPU slave side); ram_* (single RAM port, 1-cycle read latency);
//   MonDReg/monitor_ready (JTAG read result); jtag_busy/jtag_overrun.
module nios2_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    JTAG_RD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] jaddr;
  logic              pend_valid;
  logic              pend_wr;
  logic [31:0]       pend_data;
  logic              last_jtag;
  logic [31:0]       rd_hold;
  logic [31:0]       mon_q;
  logic              mon_rdy;
  logic              ovr;

  logic cpu_req;
  logic idle;
  logic grant_jtag;
  logic grant_cpu;
  logic jtag_done;
  logic any_strobe;
  logic sel_b;
  logic sel_a;
  logic sel_n;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // CPU request is masked in reset so every output sits at its reset value.
  assign cpu_req    = reset_n & (av_read | av_write);
  assign idle       = (state == IDLE);
  assign grant_jtag = idle & pend_valid & (~cpu_req | ~last_jtag);
  assign grant_cpu  = idle & cpu_req & ~grant_jtag;
  assign jtag_done  = (grant_jtag & pend_wr) | (state == JTAG_RD);

  assign sel_b      = take_action_ocimem_b;
  assign sel_a      = take_action_ocimem_a & ~take_action_ocimem_b;
  assign sel_n      = take_no_action_ocimem_a
                    & ~take_action_ocimem_a
                    & ~take_action_ocimem_b;
  assign any_strobe = sel_b | sel_a | sel_n;

  assign MonDReg       = mon_q;
  assign monitor_ready = mon_rdy;
  assign jtag_busy     = pend_valid;
  assign jtag_overrun  = ovr;

  always_comb begin
    ram_wren       = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;
    ram_byteenable = '0;
    av_waitrequest = 1'b1;
    av_readdata    = rd_hold;
    if (grant_cpu) begin
      ram_addr = av_address;
      if (av_write) begin
        ram_wren       = 1'b1;
        ram_wdata      = av_writedata;
        ram_byteenable = av_byteenable;
        av_waitrequest = 1'b0;
      end
    end else if (grant_jtag) begin
      ram_addr = jaddr;
      if (pend_wr) begin
        ram_wren       = 1'b1;
        ram_wdata      = pend_data;
        ram_byteenable = 4'hF;
      end
    end
    if (state == CPU_RD) begin
      av_readdata    = ram_rdata;
      av_waitrequest = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      jaddr      <= '0;
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      pend_data  <= '0;
      last_jtag  <= 1'b0;
      rd_hold    <= '0;
      mon_q      <= '0;
      mon_rdy    <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu && !av_write)
            state <= CPU_RD;
          else if (grant_jtag && !pend_wr)
            state <= JTAG_RD;
        end
        CPU_RD: begin
          rd_hold <= ram_rdata;
          state   <= IDLE;
        end
        JTAG_RD: begin
          mon_q   <= ram_rdata;
          mon_rdy <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (grant_cpu)
        last_jtag <= 1'b0;
      else if (grant_jtag)
        last_jtag <= 1'b1;

      if (jtag_done) begin
        pend_valid <= 1'b0;
        jaddr      <= jaddr + ADDR_W'(1);
      end

      // A completion implies the slot is busy, so an accepted strobe
      // never collides with it; the load still sits last to win.
      if (any_strobe && pend_valid) begin
        ovr <= 1'b1;
      end else if (any_strobe) begin
        unique case (1'b1)
          sel_b: begin
            pend_valid <= 1'b1;
            pend_wr    <= 1'b1;
            pend_data  <= jdo[34:3];
          end
          sel_a: begin
            jaddr <= jdo[10 +: ADDR_W];
            ovr   <= 1'b0;
            if (jdo[34]) begin
              pend_valid <= 1'b1;
              pend_wr    <= 1'b0;
              mon_rdy    <= 1'b0;
            end
          end
          sel_n: begin
            pend_valid <= 1'b1;
            pend_wr    <= 1'b0;
            mon_rdy    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios2_cpu_ocimem_arbiter.sv
// Directed bench for nios2_cpu_ocimem_arbiter with a behavioural RAM and
// read-result scoreboards for the CPU and JTAG paths.
module tb_nios2_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_busy;
  logic        jtag_overrun;

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  logic [31:0] jq[$];
  logic [31:0] cq[$];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  nios2_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_byteenable          (ram_byteenable),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_busy               (jtag_busy),
    .jtag_overrun            (jtag_overrun)
  );

  always @(posedge clk) begin
    if (bd_we)
      mem[bd_addr] <= bd_data;
    else if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b])
          mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(logic [7:0] a, logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    cyc();
    bd_we   = 1'b0;
  endtask

  function automatic logic [37:0] jaw(logic [7:0] a, logic rd);
    logic [37:0] w;
    w        = '0;
    w[17:10] = a;
    w[34]    = rd;
    return w;
  endfunction

  function automatic logic [37:0] jdw(logic [31:0] d);
    logic [37:0] w;
    w       = '0;
    w[34:3] = d;
    return w;
  endfunction

  task automatic pop_j(string tag);
    logic [31:0] e;
    if (jq.size() == 0) begin
      chk({tag, "_sb_empty"}, MonDReg, 32'hxxxx_xxxx);
    end else begin
      e = jq.pop_front();
      chk(tag, MonDReg, e);
    end
  endtask

  task automatic pop_c(string tag);
    logic [31:0] e;
    if (cq.size() == 0) begin
      chk({tag, "_sb_empty"}, av_readdata, 32'hxxxx_xxxx);
    end else begin
      e = cq.pop_front();
      chk(tag, av_readdata, e);
    end
  endtask

  // Caller is already settled inside the current cycle.
  task automatic jtag_result(string tag);
    bit got = 0;
    for (int i = 0; i < 12; i++) begin
      if (monitor_ready === 1'b1) begin
        got = 1;
        break;
      end
      cyc();
      #2;
    end
    if (got) pop_j(tag);
    else chk({tag, "_timeout"}, {31'b0, monitor_ready}, 32'd1);
  endtask

  task automatic cpu_read(string tag, logic [7:0] a,
                          logic [31:0] d, int exp_ws);
    int ws = 0;
    bit got = 0;
    cq.push_back(d);
    av_read    = 1'b1;
    av_address = a;
    #2;
    for (int i = 0; i < 10; i++) begin
      if (av_waitrequest === 1'b0) begin
        got = 1;
        break;
      end
      ws++;
      cyc();
      #2;
    end
    if (got) pop_c(tag);
    else chk({tag, "_timeout"}, {31'b0, av_waitrequest}, 32'd0);
    chk({tag, "_ws"}, ws, exp_ws);
    cyc();
    av_read = 1'b0;
  endtask

  initial begin
    reset_n                 = 1'b0;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    av_address              = '0;
    av_read                 = 1'b0;
    av_write                = 1'b0;
    av_writedata            = '0;
    av_byteenable           = '0;
    bd_we                   = 1'b0;
    bd_addr                 = '0;
    bd_data                 = '0;

    cyc();
    bd_write(8'h20, 32'hDEADBEEF);
    bd_write(8'h21, 32'hCAFEF00D);
    bd_write(8'h22, 32'h22222222);
    bd_write(8'h10, 32'h11111111);
    bd_write(8'h05, 32'hAAAAAAAA);
    bd_write(8'h01, 32'hA5A50001);
    bd_write(8'h02, 32'h02020202);
    bd_write(8'h40, 32'h40404040);
    bd_write(8'hFE, 32'h0);
    bd_write(8'hFF, 32'h0);
    bd_write(8'h00, 32'h0);
    #2;
    chk("rst_mon", MonDReg, 32'h0);
    chk("rst_mrdy", monitor_ready, 1'b0);
    chk("rst_busy", jtag_busy, 1'b0);
    chk("rst_ovr", jtag_overrun, 1'b0);
    chk("rst_rdata", av_readdata, 32'h0);
    chk("rst_wait", av_waitrequest, 1'b1);
    chk("rst_wren", ram_wren, 1'b0);
    chk("rst_addr", ram_addr, 8'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("rst_be", ram_byteenable, 4'h0);

    cyc();
    reset_n = 1'b1;
    cyc();

    // Load 0x20 + read, contended by a CPU read: JTAG wins first tie.
    jdo = jaw(8'h20, 1'b1);
    take_action_ocimem_a = 1'b1;
    jq.push_back(32'hDEADBEEF);
    #2;
    chk("busy_pre", jtag_busy, 1'b0);
    cyc();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    av_read = 1'b1;
    av_address = 8'h10;
    cq.push_back(32'h11111111);
    #2;
    chk("busy_rise", jtag_busy, 1'b1);
    chk("tie_wait1", av_waitrequest, 1'b1);
    chk("tie_jtag_addr", ram_addr, 8'h20);
    cyc();
    #2;
    chk("tie_wait2", av_waitrequest, 1'b1);
    chk("mrdy_early", monitor_ready, 1'b0);
    cyc();
    #2;
    chk("tie_wait3", av_waitrequest, 1'b1);
    chk("tie_cpu_addr", ram_addr, 8'h10);
    chk("busy_fall", jtag_busy, 1'b0);
    chk("mrdy_20", monitor_ready, 1'b1);
    pop_j("mon_20");
    cyc();
    #2;
    chk("tie_served", av_waitrequest, 1'b0);
    pop_c("cpu_rd_10");
    cyc();
    av_read = 1'b0;
    #2;
    chk("rdata_hold", av_readdata, 32'h11111111);

    // Address auto-incremented to 0x21.
    take_no_action_ocimem_a = 1'b1;
    jq.push_back(32'hCAFEF00D);
    cyc();
    take_no_action_ocimem_a = 1'b0;
    #2;
    chk("post_clr_mrdy", monitor_ready, 1'b0);
    jtag_result("mon_21");

    // Last grant was JTAG, so this tie goes to the CPU.
    cyc();
    take_no_action_ocimem_a = 1'b1;
    jq.push_back(32'h22222222);
    cyc();
    take_no_action_ocimem_a = 1'b0;
    av_read = 1'b1;
    av_address = 8'h10;
    cq.push_back(32'h11111111);
    #2;
    chk("rr_cpu_addr", ram_addr, 8'h10);
    chk("rr_cpu_wait", av_waitrequest, 1'b1);
    cyc();
    #2;
    chk("rr_cpu_done", av_waitrequest, 1'b0);
    pop_c("rr_cpu_data");
    cyc();
    av_read = 1'b0;
    #2;
    chk("rr_jtag_addr", ram_addr, 8'h22);
    jtag_result("mon_22");

    // JTAG write burst across the address wrap.
    cyc();
    take_action_ocimem_a = 1'b1;
    jdo = jaw(8'hFE, 1'b0);
    cyc();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    #2;
    chk("load_only_busy", jtag_busy, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      take_action_ocimem_b = 1'b1;
      jdo = jdw(k);
      cyc();
      take_action_ocimem_b = 1'b0;
      jdo = '0;
      #2;
      chk("jwr_wren", ram_wren, 1'b1);
      chk("jwr_wdata", ram_wdata, k);
      if (k == 1) begin
        chk("jwr_addr", ram_addr, 8'hFE);
        chk("jwr_be", ram_byteenable, 4'hF);
      end
      cyc();
      cyc();
      cyc();
    end
    chk("mem_fe", mem[8'hFE], 32'd1);
    chk("mem_ff", mem[8'hFF], 32'd2);
    chk("mem_00", mem[8'h00], 32'd3);
    take_no_action_ocimem_a = 1'b1;
    jq.push_back(32'hA5A50001);
    cyc();
    take_no_action_ocimem_a = 1'b0;
    #2;
    jtag_result("wrap_jaddr_01");

    // CPU write: zero wait states, low two bytes only.
    cyc();
    av_write = 1'b1;
    av_address = 8'h05;
    av_writedata = 32'h12345678;
    av_byteenable = 4'b0011;
    #2;
    chk("cpu_wr_nows", av_waitrequest, 1'b0);
    chk("cpu_wr_wren", ram_wren, 1'b1);
    chk("cpu_wr_be", ram_byteenable, 4'b0011);
    cyc();
    av_write = 1'b0;
    av_writedata = '0;
    av_byteenable = '0;
    cyc();
    chk("mem_05", mem[8'h05], 32'hAAAA5678);
    cpu_read("cpu_rd_05", 8'h05, 32'hAAAA5678, 1);

    // Read and write together is a write.
    av_read = 1'b1;
    av_write = 1'b1;
    av_address = 8'h06;
    av_writedata = 32'h00000077;
    av_byteenable = 4'hF;
    #2;
    chk("rw_nows", av_waitrequest, 1'b0);
    chk("rw_wren", ram_wren, 1'b1);
    cyc();
    av_read = 1'b0;
    av_write = 1'b0;
    av_byteenable = '0;
    #2;
    chk("mem_06", mem[8'h06], 32'h00000077);

    // Overrun: second back-to-back strobe dropped during a CPU read.
    cyc();
    av_read = 1'b1;
    av_address = 8'h10;
    take_no_action_ocimem_a = 1'b1;
    cq.push_back(32'h11111111);
    jq.push_back(32'h02020202);
    #2;
    chk("ovr_cpu_addr", ram_addr, 8'h10);
    cyc();
    #2;
    chk("ovr_cpu_done", av_waitrequest, 1'b0);
    pop_c("ovr_cpu_data");
    chk("ovr_busy", jtag_busy, 1'b1);
    cyc();
    take_no_action_ocimem_a = 1'b0;
    av_read = 1'b0;
    #2;
    chk("ovr_set", jtag_overrun, 1'b1);
    jtag_result("ovr_mon_02");
    cyc();
    take_action_ocimem_a = 1'b1;
    jdo = jaw(8'h30, 1'b0);
    cyc();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    #2;
    chk("ovr_clr", jtag_overrun, 1'b0);
    chk("ovr_clr_busy", jtag_busy, 1'b0);

    // Reset while the JTAG read is in JTAG_RD.
    cyc();
    take_action_ocimem_a = 1'b1;
    jdo = jaw(8'h40, 1'b1);
    cyc();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    cyc();
    #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_mon", MonDReg, 32'h0);
    chk("mrst_mrdy", monitor_ready, 1'b0);
    chk("mrst_busy", jtag_busy, 1'b0);
    chk("mrst_wait", av_waitrequest, 1'b1);
    chk("mrst_wren", ram_wren, 1'b0);
    chk("mrst_addr", ram_addr, 8'h0);
    chk("mrst_rdata", av_readdata, 32'h0);
    cyc();
    cyc();
    #2;
    chk("mrst_mon_hold", MonDReg, 32'h0);
    chk("mrst_mem_40", mem[8'h40], 32'h40404040);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
